mux_n_skid_reg: RTL and testbench

//   Parametrised N:1 selector with a registered, back-pressured output stage.

---
 rtl/mux_n_skid_reg.sv | 115 +++++++++++
 tb/tb_mux_n_skid_reg.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mux_n_skid_reg.sv
// N:1 selector feeding a 2-entry skid buffer with valid/ready handshake,
// flush and out-of-range select detection.
module mux_n_skid_reg #(
  parameter int unsigned         WIDTH       = 5,
  parameter int unsigned         NUM_PORTS   = 3,
  parameter int unsigned         SEL_W       = 2,
  parameter logic [WIDTH-1:0]    DEFAULT_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PORTS*WIDTH-1:0] PortsIn,
  input  logic [SEL_W-1:0]           Select,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic                       Flush,
  output logic [WIDTH-1:0]           Output,
  output logic                       OutSelErr,
  output logic                       OutValid,
  input  logic                       OutReady
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_data;
  logic             main_err;
  logic             main_valid;
  logic [WIDTH-1:0] skid_data;
  logic             skid_err;
  logic             skid_valid;

  logic [WIDTH-1:0] mux_data;
  logic             mux_err;
  logic             in_fire;
  logic             out_fire;

  // Unmatched select codes fall through to DEFAULT_VAL with the error flag set.
  always_comb begin
    mux_data = DEFAULT_VAL;
    mux_err  = 1'b1;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (Select == SEL_W'(k)) begin
        mux_data = PortsIn[k*WIDTH +: WIDTH];
        mux_err  = 1'b0;
      end
    end
  end

  assign InReady   = !skid_valid && !Flush;
  assign in_fire   = InValid && InReady;
  assign out_fire  = main_valid && OutReady;

  assign Output    = main_data;
  assign OutSelErr = main_err;
  assign OutValid  = main_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      main_data  <= '0;
      main_err   <= 1'b0;
      main_valid <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
      skid_valid <= 1'b0;
    end else if (Flush) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state      <= ONE;
            main_data  <= mux_data;
            main_err   <= mux_err;
            main_valid <= 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data <= mux_data;
            main_err  <= mux_err;
          end else if (in_fire) begin
            state      <= TWO;
            skid_data  <= mux_data;
            skid_err   <= mux_err;
            skid_valid <= 1'b1;
          end else if (out_fire) begin
            state      <= EMPTY;
            main_valid <= 1'b0;
          end
        end
        TWO: begin
          if (out_fire) begin
            state      <= ONE;
            main_data  <= skid_data;
            main_err   <= skid_err;
            skid_valid <= 1'b0;
          end
        end
        default: begin
          state      <= EMPTY;
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_n_skid_reg.sv
// Directed bench for mux_n_skid_reg: reset, select sweep, range check,
// back-pressure, flush and mid-operation reset.
module tb_mux_n_skid_reg;

  localparam int unsigned WIDTH     = 5;
  localparam int unsigned NUM_PORTS = 3;
  localparam int unsigned SEL_W     = 2;

  logic                       clk;
  logic                       rst_n;
  logic [NUM_PORTS*WIDTH-1:0] PortsIn;
  logic [SEL_W-1:0]           Select;
  logic                       InValid;
  logic                       InReady;
  logic                       Flush;
  logic [WIDTH-1:0]           Output;
  logic                       OutSelErr;
  logic                       OutValid;
  logic                       OutReady;

  int tests;
  int fails;

  mux_n_skid_reg #(
    .WIDTH      (WIDTH),
    .NUM_PORTS  (NUM_PORTS),
    .SEL_W      (SEL_W),
    .DEFAULT_VAL(5'd0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .PortsIn  (PortsIn),
    .Select   (Select),
    .InValid  (InValid),
    .InReady  (InReady),
    .Flush    (Flush),
    .Output   (Output),
    .OutSelErr(OutSelErr),
    .OutValid (OutValid),
    .OutReady (OutReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    InValid  = 1'b0;
    OutReady = 1'b0;
    Flush    = 1'b0;
    Select   = '0;
    PortsIn  = {5'd31, 5'd17, 5'd8};

    // 1: reset
    step();
    step();
    chk("rst_valid", 32'(OutValid), 0);
    chk("rst_data", 32'(Output), 0);
    chk("rst_err", 32'(OutSelErr), 0);
    rst_n = 1'b1;
    step();
    chk("rst_ready", 32'(InReady), 1);
    chk("rst_valid_after", 32'(OutValid), 0);

    // 2: select sweep with full throughput
    OutReady = 1'b1;
    InValid  = 1'b1;
    Select   = 2'd0;
    step();
    chk("sweep0_data", 32'(Output), 8);
    chk("sweep0_valid", 32'(OutValid), 1);
    chk("sweep0_err", 32'(OutSelErr), 0);
    Select = 2'd1;
    step();
    chk("sweep1_data", 32'(Output), 17);
    chk("sweep1_valid", 32'(OutValid), 1);
    chk("sweep1_ready", 32'(InReady), 1);
    Select = 2'd2;
    step();
    chk("sweep2_data", 32'(Output), 31);
    chk("sweep2_valid", 32'(OutValid), 1);

    // 3: out-of-range select
    Select = 2'd3;
    step();
    chk("range_data", 32'(Output), 0);
    chk("range_err", 32'(OutSelErr), 1);
    chk("range_valid", 32'(OutValid), 1);
    InValid = 1'b0;
    step();
    chk("drain_empty", 32'(OutValid), 0);

    // 4: back-pressure into the skid slot
    OutReady = 1'b0;
    InValid  = 1'b1;
    Select   = 2'd0;
    step();
    chk("bp1_data", 32'(Output), 8);
    chk("bp1_ready", 32'(InReady), 1);
    Select = 2'd1;
    step();
    chk("bp2_data", 32'(Output), 8);
    chk("bp2_ready", 32'(InReady), 0);
    InValid = 1'b0;
    step();
    chk("bp_hold_data", 32'(Output), 8);
    chk("bp_hold_valid", 32'(OutValid), 1);
    chk("bp_hold_ready", 32'(InReady), 0);
    OutReady = 1'b1;
    step();
    chk("bp_drain1_data", 32'(Output), 17);
    chk("bp_drain1_valid", 32'(OutValid), 1);
    chk("bp_drain1_err", 32'(OutSelErr), 0);
    chk("bp_drain1_ready", 32'(InReady), 1);
    step();
    chk("bp_drain2_valid", 32'(OutValid), 0);

    // 5: flush while full with a word offered
    OutReady = 1'b0;
    InValid  = 1'b1;
    Select   = 2'd0;
    step();
    Select = 2'd1;
    step();
    chk("fl_full_ready", 32'(InReady), 0);
    Flush  = 1'b1;
    Select = 2'd2;
    #1;
    chk("fl_ready_during", 32'(InReady), 0);
    step();
    chk("fl_valid", 32'(OutValid), 0);
    Flush   = 1'b0;
    InValid = 1'b0;
    #1;
    chk("fl_ready_after", 32'(InReady), 1);
    step();
    chk("fl_dropped", 32'(OutValid), 0);

    // 6: reset while full
    InValid = 1'b1;
    Select  = 2'd2;
    step();
    chk("rst2_fill_data", 32'(Output), 31);
    Select = 2'd0;
    step();
    chk("rst2_full_ready", 32'(InReady), 0);
    rst_n   = 1'b0;
    InValid = 1'b0;
    step();
    chk("rst2_valid", 32'(OutValid), 0);
    chk("rst2_data", 32'(Output), 0);
    chk("rst2_err", 32'(OutSelErr), 0);
    rst_n = 1'b1;
    #1;
    chk("rst2_ready", 32'(InReady), 1);

    // error flag carried through the skid slot
    OutReady = 1'b0;
    InValid  = 1'b1;
    Select   = 2'd1;
    step();
    chk("skerr_head", 32'(Output), 17);
    Select = 2'd3;
    step();
    chk("skerr_head_err", 32'(OutSelErr), 0);
    InValid  = 1'b0;
    OutReady = 1'b1;
    step();
    chk("skerr_data", 32'(Output), 0);
    chk("skerr_err", 32'(OutSelErr), 1);
    chk("skerr_valid", 32'(OutValid), 1);
    step();
    chk("skerr_empty", 32'(OutValid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
